// File: rtl/alu_req_driver.sv
// alu_req_driver: queues ALU commands in a small FIFO, drives them one at a time
// onto a combinational ALU, waits LAT cycles, and returns the captured result
// with the caller's tag over a valid/ready response channel, in command order.
module alu_req_driver #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [4:0]       cmd_shamt,
    input  logic [3:0]       cmd_tag,

    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryFlag,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic [3:0]       rsp_tag,
    output logic             rsp_illegal,
    output logic             busy
);

    localparam int unsigned OPW  = 4;
    localparam int unsigned SHW  = 5;
    localparam int unsigned TAGW = 4;
    localparam int unsigned CNTW = 2;
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam logic [OPW-1:0] OP_MAX = OPW'(7);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // FIFO storage, one array per command field
    logic [OPW-1:0]   r_fifo_op    [DEPTH];
    logic [WIDTH-1:0] r_fifo_a     [DEPTH];
    logic [WIDTH-1:0] r_fifo_b     [DEPTH];
    logic [SHW-1:0]   r_fifo_sh    [DEPTH];
    logic [TAGW-1:0]  r_fifo_tag   [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNTW-1:0]  r_cnt;
    logic [CNTW-1:0]  w_cnt_nxt;

    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic             r_busy;
    logic [OPW-1:0]   r_alu_opcode;
    logic [WIDTH-1:0] r_alu_input1;
    logic [WIDTH-1:0] r_alu_input2;
    logic [SHW-1:0]   r_alu_shift;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_carry;
    logic [TAGW-1:0]  r_rsp_tag;
    logic             r_rsp_illegal;

    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic             w_head_illegal;
    logic [CW-1:0]    w_count_nxt;
    logic [AW-1:0]    w_wr_ptr_inc;
    logic [AW-1:0]    w_rd_ptr_inc;

    assign w_empty        = (r_count == '0);
    assign w_push         = cmd_valid && r_cmd_ready;
    assign w_head_illegal = (r_fifo_op[r_rd_ptr] > OP_MAX);
    assign w_wr_ptr_inc   = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
    assign w_rd_ptr_inc   = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);

    // Occupancy after this edge's push/pop
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO payload write; storage needs no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]  <= cmd_opcode;
            r_fifo_a[r_wr_ptr]   <= cmd_a;
            r_fifo_b[r_wr_ptr]   <= cmd_b;
            r_fifo_sh[r_wr_ptr]  <= cmd_shamt;
            r_fifo_tag[r_wr_ptr] <= cmd_tag;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= w_count_nxt;
        end
    end

    // FSM state and latency counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next state: pop from IDLE or on a RESP handshake, count down in WAIT
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNTW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Illegal opcodes skip the ALU and respond straight away
        if (w_pop) begin
            if (w_head_illegal) begin
                w_state_nxt = S_RESP;
            end else begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = CNTW'(LAT);
            end
        end
    end

    // Handshake and status flags, registered from next-cycle state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cmd_ready <= (w_count_nxt != CW'(DEPTH));
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_busy      <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
        end
    end

    // ALU drive registers: loaded only on a legal pop, otherwise held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_opcode <= '0;
            r_alu_input1 <= '0;
            r_alu_input2 <= '0;
            r_alu_shift  <= '0;
        end else if (w_pop && !w_head_illegal) begin
            r_alu_opcode <= r_fifo_op[r_rd_ptr];
            r_alu_input1 <= r_fifo_a[r_rd_ptr];
            r_alu_input2 <= r_fifo_b[r_rd_ptr];
            r_alu_shift  <= r_fifo_sh[r_rd_ptr];
        end
    end

    // Response payload: tag on pop, result on capture or zeroed for illegal
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_result  <= '0;
            r_rsp_carry   <= 1'b0;
            r_rsp_tag     <= '0;
            r_rsp_illegal <= 1'b0;
        end else if (w_pop) begin
            r_rsp_tag <= r_fifo_tag[r_rd_ptr];
            if (w_head_illegal) begin
                r_rsp_result  <= '0;
                r_rsp_carry   <= 1'b0;
                r_rsp_illegal <= 1'b1;
            end
        end else if (w_capture) begin
            r_rsp_result  <= alu_result;
            r_rsp_carry   <= alu_carryFlag;
            r_rsp_illegal <= 1'b0;
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign alu_opcode     = r_alu_opcode;
    assign alu_input1     = r_alu_input1;
    assign alu_input2     = r_alu_input2;
    assign alu_shiftValue = r_alu_shift;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_result     = r_rsp_result;
    assign rsp_carry      = r_rsp_carry;
    assign rsp_tag        = r_rsp_tag;
    assign rsp_illegal    = r_rsp_illegal;
    assign busy           = r_busy;

endmodule

// File: tb/tb_alu_req_driver.sv
// Testbench for alu_req_driver: behavioural ALU, response scoreboard,
// directed latency/capacity/reset scenarios and randomized traffic.
module tb_alu_req_driver;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [4:0]       cmd_shamt;
    logic [3:0]       cmd_tag;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_input1;
    logic [WIDTH-1:0] alu_input2;
    logic [4:0]       alu_shiftValue;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carryFlag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic [3:0]       rsp_tag;
    logic             rsp_illegal;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic [3:0]       tag;
        logic             ill;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rsp    = 0;
    logic prev_stall = 1'b0;

    alu_req_driver #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result), .alu_carryFlag(alu_carryFlag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {carry, result}
    function automatic logic [WIDTH:0] alu_model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b, input logic [4:0] sh);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            4'd0: r = {1'b0, a} + {1'b0, b};
            4'd1: begin r[WIDTH-1:0] = a - b; r[WIDTH] = (a < b); end
            4'd2: r[WIDTH-1:0] = a & b;
            4'd3: r[WIDTH-1:0] = a | b;
            4'd4: r[WIDTH-1:0] = a << sh;
            4'd5: r[WIDTH-1:0] = ($signed(a) > $signed(b)) ? WIDTH'(1) : '0;
            4'd6: r[WIDTH-1:0] = (sh == 5'd0) ? a : ((a >> sh) | (a << (6'd32 - {1'b0, sh})));
            4'd7: r[WIDTH-1:0] = (a < b) ? WIDTH'(1) : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign {alu_carryFlag, alu_result} = alu_model(alu_opcode, alu_input1, alu_input2, alu_shiftValue);

    // Expected response for a command, straight from the opcode rules
    function automatic rsp_t expect_rsp(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b, input logic [4:0] sh,
                                        input logic [3:0] tag);
        rsp_t e;
        logic [WIDTH:0] r;
        if (op > 4'd7) begin
            e = '{res: '0, carry: 1'b0, tag: tag, ill: 1'b1};
        end else begin
            r = alu_model(op, a, b, sh);
            e = '{res: r[WIDTH-1:0], carry: r[WIDTH], tag: tag, ill: 1'b0};
        end
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid response cycle must match the oldest outstanding command
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check_eq("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    check_eq("rsp_fields", 64'({rsp_result, rsp_carry, rsp_tag, rsp_illegal}),
                             64'(exp_q[0]));
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        n_rsp++;
                    end
                end
            end
            if (cmd_valid && cmd_ready)
                exp_q.push_back(expect_rsp(cmd_opcode, cmd_a, cmd_b, cmd_shamt, cmd_tag));
            prev_stall = rsp_valid && !rsp_ready;
        end
    end

    task automatic drive_cmd(input logic [3:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [4:0] sh, input logic [3:0] tag);
        int n;
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; cmd_tag = tag;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin tick(); n++; end
        check_eq("cmd_accept_timeout", 64'(n < 100), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin tick(); n++; end
        check_eq("idle_timeout", 64'(n < 300), 64'd1);
    endtask

    task automatic run_random(input int ncmd);
        int   issued;
        int   base;
        int   c;
        logic acc;
        issued = 0; base = n_rsp; c = 0;
        while ((issued < ncmd || (n_rsp - base) < ncmd) && c < ncmd * 40 + 100) begin
            rsp_ready = 1'($urandom_range(0, 1));
            if (issued < ncmd && !cmd_valid && $urandom_range(0, 3) != 0) begin
                cmd_opcode = 4'($urandom_range(0, 9));
                cmd_a      = $urandom;
                cmd_b      = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
                cmd_shamt  = 5'($urandom);
                cmd_tag    = 4'(issued);
                cmd_valid  = 1'b1;
            end
            acc = cmd_valid && cmd_ready;
            tick();
            c++;
            if (acc) begin issued++; cmd_valid = 1'b0; end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        check_eq("rnd_rsp_count", 64'(n_rsp - base), 64'(ncmd));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int accepts;
        int seen;
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_shamt = '0; cmd_tag = '0;
        repeat (3) tick();

        // Reset values
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_alu", 64'({alu_opcode, alu_shiftValue}), 64'd0);
        check_eq("rst_alu_in", 64'({alu_input1, alu_input2}), 64'd0);
        check_eq("rst_rsp", 64'({rsp_result, rsp_carry, rsp_tag, rsp_illegal}), 64'd0);
        rst = 1'b0;
        tick();

        // ADD with carry out, latency 2+LAT
        rsp_ready = 1'b1;
        drive_cmd(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd0, 4'd3);
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        check_eq("add_latency", 64'(n), 64'(2 + LAT));
        check_eq("add_result", 64'(rsp_result), 64'h0);
        check_eq("add_carry", 64'(rsp_carry), 64'd1);
        check_eq("add_tag", 64'(rsp_tag), 64'd3);
        check_eq("add_illegal", 64'(rsp_illegal), 64'd0);
        wait_idle();

        // SLL by 31, shift amount held on the ALU until capture
        drive_cmd(4'd4, 32'h1, 32'h0, 5'd31, 4'd5);
        tick();
        check_eq("sll_shift_c1", 64'(alu_shiftValue), 64'd31);
        check_eq("sll_valid_c1", 64'(rsp_valid), 64'd0);
        tick();
        check_eq("sll_shift_c2", 64'(alu_shiftValue), 64'd31);
        check_eq("sll_valid_c2", 64'(rsp_valid), 64'd0);
        tick();
        check_eq("sll_valid_c3", 64'(rsp_valid), 64'd1);
        check_eq("sll_result", 64'(rsp_result), 64'h8000_0000);
        check_eq("sll_tag", 64'(rsp_tag), 64'd5);
        wait_idle();

        // Illegal opcode: one-cycle latency, ALU drive untouched
        drive_cmd(4'd9, 32'h1234, 32'h5678, 5'd3, 4'd7);
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        check_eq("ill_latency", 64'(n), 64'd1);
        check_eq("ill_flag", 64'(rsp_illegal), 64'd1);
        check_eq("ill_result", 64'({rsp_result, rsp_carry}), 64'd0);
        check_eq("ill_tag", 64'(rsp_tag), 64'd7);
        check_eq("ill_alu_hold", 64'({alu_opcode, alu_shiftValue}), 64'({4'd4, 5'd31}));
        check_eq("ill_alu_in_hold", 64'({alu_input1, alu_input2}), 64'({32'h1, 32'h0}));
        wait_idle();

        // Capacity with responses blocked: DEPTH queued plus one in flight
        rsp_ready = 1'b0;
        accepts = 0;
        for (int c = 0; c < 12; c++) begin
            cmd_valid = (accepts < 8);
            cmd_opcode = 4'd0; cmd_a = WIDTH'(c); cmd_b = 32'h10; cmd_shamt = '0;
            cmd_tag = 4'(accepts);
            if (cmd_valid && cmd_ready) accepts++;
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("cap_accepts", 64'(accepts), 64'(DEPTH + 1));
        check_eq("cap_ready_low", 64'(cmd_ready), 64'd0);
        check_eq("cap_head", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 4'd0}));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("cap_ready_back", 64'(cmd_ready), 64'd1);
        check_eq("cap_valid_drop", 64'(rsp_valid), 64'd0);
        check_eq("cap_next_a", 64'(alu_input1), 64'd1);
        wait_idle();

        // Ordering under random back-pressure, then a longer random run
        run_random(4);
        wait_idle();
        run_random(60);
        wait_idle();

        // Reset in WAIT with two commands queued
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = 32'h5; cmd_b = 32'h6; cmd_shamt = '0;
        cmd_tag = 4'd10; tick();
        cmd_tag = 4'd11; tick();
        cmd_tag = 4'd12; tick();
        cmd_valid = 1'b0;
        check_eq("mid_busy", 64'({busy, rsp_valid}), 64'({1'b1, 1'b0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_ready", 64'(cmd_ready), 64'd1);
        check_eq("mid_rst_alu", 64'({alu_opcode, alu_shiftValue}), 64'd0);
        check_eq("mid_rst_alu_in", 64'({alu_input1, alu_input2}), 64'd0);
        rsp_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (rsp_valid) seen++;
        end
        check_eq("mid_no_rsp", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
